frog_input_ctrl: RTL and testbench
==================================

# frog_input_ctrl

Front-end for the player switches: synchronizes and debounces the four raw push-switches and converts presses into a buffered move-command stream for the frog movement controller. It also detects the four-switch reset combination. It sits between the board switch pins and the frog controller / game top, and is the initiating side of the move interface that the frog controller consumes. A valid/ready handshake makes sure each debounced press produces exactly one accepted move, with optional hold-to-repeat.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable clocks required to accept a switch level change (10 ms at 25 MHz); minimum 1.
- REPEAT_DELAY, default 6250000: clocks a single held switch must stay pressed before the first auto-repeat; 0 disables auto-repeat.
- REPEAT_PERIOD, default 3125000: clocks between subsequent auto-repeats; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- switch1  in  1  raw switch, move up; asynchronous; 1 = pressed.
- switch2  in  1  raw switch, move down.
- switch3  in  1  raw switch, move left.
- switch4  in  1  raw switch, move right.
- move_valid  out  1  a move command is pending.
- move_dir  out  2  command direction: 0 up, 1 down, 2 left, 3 right; meaningful only while move_valid = 1.
- move_ready  in  1  consumer accepts the command this cycle.
- combo_reset  out  1  one-cycle pulse when all four switches become debounced-pressed.
- switches_stable  out  4  debounced levels {switch4, switch3, switch2, switch1}.

## Operation

- **Reset values** (async assert, sync-safe release): sync flops 0, debounce counters 0, switches_stable 4'b0000, move_valid 0, move_dir 2'd0, combo_reset 0, repeat counter 0, combo armed.
- **Synchronizer:** 2-flop synchronizer per switch; downstream logic sees only stage 2.
- **Debouncer:** one counter per switch, width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever synced value equals the stable value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the stable bit toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the stable bit.
- **Press event:** a stable bit going 0→1.
  - If several bits rise in the same cycle, a single event is issued using priority up > down > left > right; the others are discarded.
- **Auto-repeat** (REPEAT_DELAY ≠ 0):
  - Active only while exactly one stable bit is 1.
  - The counter starts at that bit's press event. It emits a repeat event for the same direction after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Any change of the stable vector restarts or stops the counter.
- **Output buffer** (one entry, states EMPTY/FULL):
  - EMPTY + event → FULL, load move_dir.
  - FULL + move_ready → EMPTY, unless a new event arrives in the same cycle; then it stays FULL and loads the new direction.
  - FULL + event without move_ready → event dropped. move_dir and move_valid stay unchanged (stable while valid).
- **Combo:**
  - When the stable vector becomes 4'b1111 while armed: combo_reset pulses for 1 cycle, the buffer is forced EMPTY, and the unit disarms.
  - While disarmed, no press or repeat events are generated.
  - It re-arms when the stable vector returns to 4'b0000.
- Reset asserted mid-operation clears everything immediately; a pending command is lost.

## Timing

- A raw level held constant is captured by sync stage 1 at edge 1 and stage 2 at edge 2. The counter counts edges 3..DEBOUNCE_CYCLES+2, and the stable bit changes at edge DEBOUNCE_CYCLES+2.
- move_valid (or combo_reset) rises at edge DEBOUNCE_CYCLES+3 after the raw change.
- Handshake completes on any edge where move_valid and move_ready are both 1. move_valid falls on that edge unless a same-cycle event reloads it.
- The consumer may hold move_ready high permanently; throughput is one command per cycle.
- Auto-repeat events occur REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, ... cycles after the initial press event.

## Test plan

Run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.

1. Reset, then raise switch1 and hold, move_ready=1 → switches_stable=4'b0001 at edge 6; move_valid=1, move_dir=0 at edge 7 for exactly 1 cycle; repeats at +20 and +28 cycles.
2. switch3 glitch high for 3 cycles → switches_stable and move_valid stay 0.
3. move_ready=0, press switch4, then switch2 while the first is pending → move_valid held, move_dir=3 stays stable; after move_ready=1, one accept, then move_valid=0 (down press dropped).
4. All four raw switches rise together → combo_reset pulses once, no move_valid; releasing switch1 and re-pressing it gives no combo (disarmed); releasing all, then pressing switch2 → move_dir=1.
5. switch2 and switch3 rise in the same cycle → single event move_dir=1; no auto-repeat while both are held.
6. reset_n low while move_valid=1 → move_valid=0, switches_stable=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/frog_input_ctrl.sv
// Player switch front-end: 2-flop synchronizer, per-switch debouncer, press/auto-repeat
// event generation, four-switch combo detection and a one-entry valid/ready move buffer.
module frog_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 6250000,
    parameter int REPEAT_PERIOD   = 3125000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       combo_reset,
    output logic [3:0] switches_stable
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);
    localparam logic             RPT_EN    = (REPEAT_DELAY != 0);

    typedef enum logic {
        BUF_EMPTY,
        BUF_FULL
    } buf_state_t;

    // Lowest index wins: up > down > left > right.
    function automatic logic [1:0] prio_dir(input logic [3:0] v);
        logic [1:0] d;
        d = 2'd3;
        if (v[2]) d = 2'd2;
        if (v[1]) d = 2'd1;
        if (v[0]) d = 2'd0;
        return d;
    endfunction

    logic [3:0]       sw_raw;
    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       stable_p2;
    logic [3:0]       stable_p3;

    logic             armed;
    logic             rpt_active;
    logic             rpt_first;
    logic [RPT_W-1:0] rpt_cnt;
    buf_state_t       buf_state;

    logic [3:0]       rise;
    logic             chg;
    logic             onehot;
    logic             combo_evt;
    logic             press_evt;
    logic             rpt_evt;
    logic             evt;
    logic [1:0]       evt_dir;
    logic [RPT_W-1:0] rpt_target;

    assign sw_raw          = {switch4, switch3, switch2, switch1};
    assign switches_stable = stable_p2;

    // Stage 0/1: synchronizer; stage 2: debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0   <= 4'b0000;
            sync_p1   <= 4'b0000;
            stable_p2 <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == stable_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]    <= '0;
                    stable_p2[i] <= ~stable_p2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rise       = stable_p2 & ~stable_p3;
        chg        = (stable_p2 != stable_p3);
        onehot     = $onehot(stable_p2);
        combo_evt  = armed && chg && (stable_p2 == 4'b1111);
        press_evt  = armed && (rise != 4'b0000) && !combo_evt;
        rpt_target = rpt_first ? RPT_FIRST : RPT_NEXT;
        // A vector change in the same cycle pre-empts a due repeat.
        rpt_evt    = RPT_EN && armed && rpt_active && !chg && (rpt_cnt == rpt_target);
        evt        = press_evt || rpt_evt;
        evt_dir    = prio_dir(press_evt ? rise : stable_p2);
    end

    // Stage 3: repeat timer, counting cycles since the last press or repeat event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_active <= 1'b0;
            rpt_first  <= 1'b1;
            rpt_cnt    <= '0;
        end else if (chg) begin
            rpt_active <= RPT_EN && press_evt && onehot;
            rpt_first  <= 1'b1;
            rpt_cnt    <= RPT_W'(1);
        end else if (rpt_active) begin
            if (rpt_evt) begin
                rpt_first <= 1'b0;
                rpt_cnt   <= RPT_W'(1);
            end else begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

    // Stage 3: combo arming and the one-entry output buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_p3   <= 4'b0000;
            armed       <= 1'b1;
            combo_reset <= 1'b0;
            buf_state   <= BUF_EMPTY;
            move_valid  <= 1'b0;
            move_dir    <= 2'd0;
        end else begin
            stable_p3   <= stable_p2;
            combo_reset <= combo_evt;
            if (combo_evt) begin
                armed <= 1'b0;
            end else if (stable_p2 == 4'b0000) begin
                armed <= 1'b1;
            end

            if (combo_evt) begin
                buf_state  <= BUF_EMPTY;
                move_valid <= 1'b0;
            end else begin
                case (buf_state)
                    BUF_EMPTY: begin
                        if (evt) begin
                            buf_state  <= BUF_FULL;
                            move_valid <= 1'b1;
                            move_dir   <= evt_dir;
                        end
                    end
                    BUF_FULL: begin
                        // Without move_ready a new event is dropped so move_dir stays stable.
                        if (move_ready) begin
                            if (evt) begin
                                move_dir <= evt_dir;
                            end else begin
                                buf_state  <= BUF_EMPTY;
                                move_valid <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        buf_state  <= BUF_EMPTY;
                        move_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Self-checking bench for frog_input_ctrl with a scoreboard of expected accepted moves.
module tb_frog_input_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       switch1, switch2, switch3, switch4;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       combo_reset;
    logic [3:0] switches_stable;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] exp_q[$];
    logic [1:0] sb_exp;
    bit         mon_en = 1'b0;

    frog_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .switch1        (switch1),
        .switch2        (switch2),
        .switch3        (switch3),
        .switch4        (switch4),
        .move_valid     (move_valid),
        .move_dir       (move_dir),
        .move_ready     (move_ready),
        .combo_reset    (combo_reset),
        .switches_stable(switches_stable)
    );

    always #5 clk = ~clk;

    // Accepted moves are compared against the scoreboard at the falling edge.
    always @(negedge clk) begin
        if (mon_en && reset_n && move_valid && move_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: accepted move_dir=%0d, expected no move", move_dir);
            end else begin
                sb_exp = exp_q.pop_front();
                if (move_dir !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_dir: accepted move_dir=%0d, expected %0d", move_dir, sb_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sw(input logic [3:0] v);
        {switch4, switch3, switch2, switch1} = v;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        move_ready = 1'b0;
        set_sw(4'b0000);
        step(3);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", move_valid); end
        n_cmp++; if (move_dir !== 2'd0) begin n_err++; $display("FAIL rst_dir: got %0d want 0", move_dir); end
        n_cmp++; if (combo_reset !== 1'b0) begin n_err++; $display("FAIL rst_combo: got %b want 0", combo_reset); end
        n_cmp++; if (switches_stable !== 4'b0000) begin n_err++; $display("FAIL rst_stable: got %b want 0000", switches_stable); end
        reset_n = 1'b1;
        step(2);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid: got %b want 0", move_valid); end
        mon_en = 1'b1;
    endtask

    task automatic test_press_repeat();
        move_ready = 1'b1;
        set_sw(4'b0001);
        exp_q.push_back(2'd0);
        step(5);
        n_cmp++; if (switches_stable !== 4'b0000) begin n_err++; $display("FAIL t1_stable_e5: got %b want 0000", switches_stable); end
        step(1);
        n_cmp++; if (switches_stable !== 4'b0001) begin n_err++; $display("FAIL t1_stable_e6: got %b want 0001", switches_stable); end
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_e6: got %b want 0", move_valid); end
        step(1);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin n_err++; $display("FAIL t1_press_e7: got valid=%b dir=%0d want valid=1 dir=0", move_valid, move_dir); end
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        step(1);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_e8: got %b want 0", move_valid); end
        step(18);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_e26: got %b want 0", move_valid); end
        step(1);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin n_err++; $display("FAIL t1_rpt1_e27: got valid=%b dir=%0d want valid=1 dir=0", move_valid, move_dir); end
        step(1);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_e28: got %b want 0", move_valid); end
        step(6);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_e34: got %b want 0", move_valid); end
        step(1);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin n_err++; $display("FAIL t1_rpt2_e35: got valid=%b dir=%0d want valid=1 dir=0", move_valid, move_dir); end
        set_sw(4'b0000);
        step(12);
        n_cmp++; if (switches_stable !== 4'b0000) begin n_err++; $display("FAIL t1_release: got %b want 0000", switches_stable); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL t1_pending: got %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_glitch();
        set_sw(4'b0100);
        step(3);
        set_sw(4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if (switches_stable !== 4'b0000 || move_valid !== 1'b0) begin
                n_err++;
                $display("FAIL t2_glitch[%0d]: got stable=%b valid=%b want 0000/0", i, switches_stable, move_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        move_ready = 1'b0;
        set_sw(4'b1000);
        exp_q.push_back(2'd3);
        step(7);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd3) begin n_err++; $display("FAIL t3_first: got valid=%b dir=%0d want valid=1 dir=3", move_valid, move_dir); end
        step(1);
        set_sw(4'b1010);
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if (move_valid !== 1'b1 || move_dir !== 2'd3) begin
                n_err++;
                $display("FAIL t3_hold[%0d]: got valid=%b dir=%0d want valid=1 dir=3", i, move_valid, move_dir);
            end
        end
        move_ready = 1'b1;
        step(1);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t3_accept: got valid=%b want 0", move_valid); end
        step(3);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t3_dropped: got valid=%b want 0", move_valid); end
        set_sw(4'b0000);
        step(10);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL t3_pending: got %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_combo();
        move_ready = 1'b1;
        set_sw(4'b1111);
        step(6);
        n_cmp++; if (combo_reset !== 1'b0) begin n_err++; $display("FAIL t4_combo_e6: got %b want 0", combo_reset); end
        step(1);
        n_cmp++; if (combo_reset !== 1'b1 || move_valid !== 1'b0) begin n_err++; $display("FAIL t4_combo_e7: got combo=%b valid=%b want 1/0", combo_reset, move_valid); end
        step(1);
        n_cmp++; if (combo_reset !== 1'b0) begin n_err++; $display("FAIL t4_combo_e8: got %b want 0", combo_reset); end
        set_sw(4'b1110);
        step(8);
        set_sw(4'b1111);
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_cmp++;
            if (combo_reset !== 1'b0 || move_valid !== 1'b0) begin
                n_err++;
                $display("FAIL t4_disarmed[%0d]: got combo=%b valid=%b want 0/0", i, combo_reset, move_valid);
            end
        end
        n_cmp++; if (switches_stable !== 4'b1111) begin n_err++; $display("FAIL t4_stable: got %b want 1111", switches_stable); end
        set_sw(4'b0000);
        step(8);
        set_sw(4'b0010);
        exp_q.push_back(2'd1);
        step(7);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd1) begin n_err++; $display("FAIL t4_rearm: got valid=%b dir=%0d want valid=1 dir=1", move_valid, move_dir); end
        set_sw(4'b0000);
        step(10);
    endtask

    task automatic test_simultaneous();
        int n_valid;
        move_ready = 1'b1;
        set_sw(4'b0110);
        exp_q.push_back(2'd1);
        step(6);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t5_valid_e6: got %b want 0", move_valid); end
        step(1);
        n_cmp++; if (move_valid !== 1'b1 || move_dir !== 2'd1) begin n_err++; $display("FAIL t5_press: got valid=%b dir=%0d want valid=1 dir=1", move_valid, move_dir); end
        n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (move_valid === 1'b1) n_valid++;
        end
        n_cmp++; if (n_valid != 0) begin n_err++; $display("FAIL t5_no_repeat: got %0d extra valid cycles want 0", n_valid); end
        set_sw(4'b0000);
        step(10);
    endtask

    task automatic test_async_reset();
        move_ready = 1'b0;
        set_sw(4'b0001);
        step(7);
        n_cmp++; if (move_valid !== 1'b1) begin n_err++; $display("FAIL t6_pending: got valid=%b want 1", move_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t6_async_valid: got %b want 0", move_valid); end
        n_cmp++; if (switches_stable !== 4'b0000) begin n_err++; $display("FAIL t6_async_stable: got %b want 0000", switches_stable); end
        set_sw(4'b0000);
        step(2);
        reset_n = 1'b1;
        step(3);
        n_cmp++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL t6_after: got valid=%b want 0", move_valid); end
    endtask

    initial begin
        test_reset();
        test_press_repeat();
        test_glitch();
        test_back_to_back();
        test_combo();
        test_simultaneous();
        test_async_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_final: got %0d outstanding moves want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
